// File: rtl/cc_pkg.sv
// Shared CC package: frame geometry and IFFT tdata field layout used by the
// FFT, IFFT and argmax blocks.
package cc_pkg;

  localparam int CC_N_LOG2 = 8;
  localparam int CC_DATA_W = 16;

  // tdata layout: real part in the low half, imaginary part in the high half
  localparam int CC_RE_LSB = 0;
  localparam int CC_IM_LSB = CC_DATA_W;

  typedef enum logic {
    ACCUM  = 1'b0,
    REPORT = 1'b1
  } argmax_state_e;

endpackage

// File: rtl/cc_argmax.sv
// Correlation peak finder: scans one IFFT frame for the largest signed real
// part and reports its bin index, discarding frames with a misplaced tlast.
module cc_argmax
  import cc_pkg::*;
#(
  parameter int DATA_W = CC_DATA_W,
  parameter int N_LOG2 = CC_N_LOG2
) (
  input  logic                     clk,
  input  logic                     reset_b,
  input  logic [2*DATA_W-1:0]      s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic                     s_axis_tlast,
  output logic [N_LOG2-1:0]        Index_out,
  output logic                     Index_valid,
  output logic signed [DATA_W-1:0] Peak_out,
  output logic                     Frame_error
);

  argmax_state_e state_q, state_d;
  logic [N_LOG2-1:0]        cnt_q, cnt_d;
  logic signed [DATA_W-1:0] max_q, max_d;
  logic [N_LOG2-1:0]        max_idx_q, max_idx_d;
  logic [N_LOG2-1:0]        idx_out_q, idx_out_d;
  logic signed [DATA_W-1:0] peak_q, peak_d;
  logic                     ivld_q, ivld_d;
  logic                     ferr_q, ferr_d;
  logic                     rdy_q, rdy_d;

  logic                     beat_ok;
  logic                     last_bin;
  logic                     take;
  logic signed [DATA_W-1:0] re;
  logic signed [DATA_W-1:0] new_max;
  logic [N_LOG2-1:0]        new_idx;
  logic                     unused_imag;

  assign re          = s_axis_tdata[CC_RE_LSB +: DATA_W];
  assign unused_imag = ^s_axis_tdata[DATA_W +: DATA_W];

  // rdy_q holds tready low through reset and for no longer
  assign rdy_d         = 1'b1;
  assign s_axis_tready = rdy_q && (state_q == ACCUM);
  assign beat_ok       = s_axis_tvalid && s_axis_tready;
  assign last_bin      = &cnt_q;

  // Strict greater-than keeps the lowest index on ties
  assign take    = (cnt_q == '0) || (re > max_q);
  assign new_max = take ? re : max_q;
  assign new_idx = take ? cnt_q : max_idx_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    max_d     = max_q;
    max_idx_d = max_idx_q;
    idx_out_d = idx_out_q;
    peak_d    = peak_q;
    ivld_d    = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      ACCUM: begin
        if (beat_ok) begin
          if (s_axis_tlast && last_bin) begin
            // Final beat folds into the result that is published now
            idx_out_d = new_idx;
            peak_d    = new_max;
            ivld_d    = 1'b1;
            state_d   = REPORT;
            cnt_d     = '0;
            max_d     = '0;
            max_idx_d = '0;
          end else if (s_axis_tlast || last_bin) begin
            // Early tlast or missing tlast at wrap: drop the frame
            ferr_d    = 1'b1;
            cnt_d     = '0;
            max_d     = '0;
            max_idx_d = '0;
          end else begin
            cnt_d     = cnt_q + 1'b1;
            max_d     = new_max;
            max_idx_d = new_idx;
          end
        end
      end
      REPORT: state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q   <= ACCUM;
      cnt_q     <= '0;
      max_q     <= '0;
      max_idx_q <= '0;
      idx_out_q <= '0;
      peak_q    <= '0;
      ivld_q    <= 1'b0;
      ferr_q    <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      max_q     <= max_d;
      max_idx_q <= max_idx_d;
      idx_out_q <= idx_out_d;
      peak_q    <= peak_d;
      ivld_q    <= ivld_d;
      ferr_q    <= ferr_d;
      rdy_q     <= rdy_d;
    end
  end

  assign Index_out   = idx_out_q;
  assign Peak_out    = peak_q;
  assign Index_valid = ivld_q;
  assign Frame_error = ferr_q;

endmodule

// File: tb/tb_cc_argmax.sv
// Scoreboard bench for cc_argmax: expected frame results are queued as the
// last beat is driven and checked when Index_valid / Frame_error pulses.
module tb_cc_argmax;

  localparam int DW = 16;
  localparam int NL = 8;
  localparam int NB = 1 << NL;

  typedef struct {
    logic              err;
    logic [NL-1:0]     idx;
    logic signed [DW-1:0] pk;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 reset_b = 1'b0;
  logic [2*DW-1:0]      s_axis_tdata = '0;
  logic                 s_axis_tvalid = 1'b0;
  logic                 s_axis_tready;
  logic                 s_axis_tlast = 1'b0;
  logic [NL-1:0]        Index_out;
  logic                 Index_valid;
  logic signed [DW-1:0] Peak_out;
  logic                 Frame_error;

  cc_argmax #(.DATA_W(DW), .N_LOG2(NL)) dut (
    .clk(clk), .reset_b(reset_b),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .Index_out(Index_out), .Index_valid(Index_valid),
    .Peak_out(Peak_out), .Frame_error(Frame_error)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_acc_cyc = 0;
  exp_t exp_q[$];
  int pulse_cyc[$];
  logic signed [DW-1:0] fr[NB];
  logic [NL-1:0]        good_idx = '0;
  logic signed [DW-1:0] good_pk = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Result monitor
  always @(negedge clk) begin
    if (reset_b && (Index_valid || Frame_error)) begin
      vectors++;
      if (Index_valid && Frame_error) begin
        miscompares++;
        $display("FAIL both_pulses: Index_valid=%0b Frame_error=%0b required not both", Index_valid, Frame_error);
      end
      vectors++;
      if (cyc !== last_acc_cyc) begin
        miscompares++;
        $display("FAIL latency: pulse at cycle %0d required %0d", cyc, last_acc_cyc);
      end
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_pulse: Index_valid=%0b Frame_error=%0b with no frame pending", Index_valid, Frame_error);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        vectors++;
        if (Frame_error !== e.err) begin
          miscompares++;
          $display("FAIL pulse_kind: Frame_error=%0b required %0b", Frame_error, e.err);
        end
        if (!e.err) begin
          pulse_cyc.push_back(cyc);
          vectors++;
          if (Index_out !== e.idx || Peak_out !== e.pk) begin
            miscompares++;
            $display("FAIL result: Index_out=%0d Peak_out=%0d required %0d %0d", Index_out, Peak_out, e.idx, e.pk);
          end
          good_idx = e.idx;
          good_pk  = e.pk;
        end else begin
          vectors++;
          if (Index_out !== good_idx || Peak_out !== good_pk) begin
            miscompares++;
            $display("FAIL err_hold: Index_out=%0d Peak_out=%0d required %0d %0d", Index_out, Peak_out, good_idx, good_pk);
          end
        end
      end
    end
  end

  // Drives fr[0..len-1]; duty is tvalid probability in percent. abort_at>=0
  // stops after that beat with nothing queued. tvalid is left high on return.
  task automatic send_frame(input int len, input int duty, input bit no_last, input int abort_at);
    exp_t e;
    logic signed [DW-1:0] mx;
    int mi;
    bit r;
    int guard;
    mx = fr[0]; mi = 0;
    for (int i = 1; i < len && i < NB; i++)
      if (fr[i] > mx) begin mx = fr[i]; mi = i; end
    e.err = (len != NB) || no_last;
    e.idx = mi[NL-1:0];
    e.pk  = mx;
    for (int b = 0; b < len; b++) begin
      while (duty < 100 && $urandom_range(99) >= duty) begin
        s_axis_tvalid = 1'b0;
        @(posedge clk); #1;
      end
      if (b == len - 1 && abort_at < 0) exp_q.push_back(e);
      s_axis_tdata  = {16'h5A5A ^ DW'(b), fr[b]};
      s_axis_tlast  = (b == len - 1) && !no_last;
      s_axis_tvalid = 1'b1;
      guard = 0;
      do begin
        @(negedge clk); r = s_axis_tready;
        @(posedge clk); #1;
        guard++;
      end while (!r && guard < 100);
      if (!r) begin
        miscompares++;
        $display("FAIL ready_timeout: beat %0d not accepted", b);
      end
      last_acc_cyc = cyc;
      if (b == abort_at) break;
    end
    s_axis_tlast = 1'b0;
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #12;
    vectors += 5;
    if (s_axis_tready !== 1'b0) begin miscompares++; $display("FAIL rst_tready: got %0b required 0", s_axis_tready); end
    if (Index_out !== '0)       begin miscompares++; $display("FAIL rst_index: got %0d required 0", Index_out); end
    if (Peak_out !== '0)        begin miscompares++; $display("FAIL rst_peak: got %0d required 0", Peak_out); end
    if (Index_valid !== 1'b0)   begin miscompares++; $display("FAIL rst_ivalid: got %0b required 0", Index_valid); end
    if (Frame_error !== 1'b0)   begin miscompares++; $display("FAIL rst_ferr: got %0b required 0", Frame_error); end
    @(negedge clk); reset_b = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (s_axis_tready !== 1'b1) begin miscompares++; $display("FAIL rel_tready: got %0b required 1", s_axis_tready); end
  endtask

  task automatic test_single_peak;
    foreach (fr[i]) fr[i] = 0;
    fr[37] = 1200;
    send_frame(NB, 100, 0, -1);
    idle(3);
  endtask

  task automatic test_ties;
    foreach (fr[i]) fr[i] = -500;
    fr[10] = 300; fr[200] = 300;
    send_frame(NB, 100, 0, -1);
    idle(2);
    foreach (fr[i]) fr[i] = -500;
    send_frame(NB, 100, 0, -1);
    idle(2);
  endtask

  task automatic test_bad_frames;
    foreach (fr[i]) fr[i] = DW'($urandom_range(2000)) - 16'sd1000;
    send_frame(100, 100, 0, -1);
    idle(2);
    send_frame(NB, 100, 1, -1);
    idle(2);
    foreach (fr[i]) fr[i] = -100;
    fr[5] = 700;
    send_frame(NB, 100, 0, -1);
    idle(2);
  endtask

  task automatic test_random_duty;
    foreach (fr[i]) fr[i] = DW'($urandom_range(60000)) - 16'sd30000;
    fr[255] = 32767;
    send_frame(NB, 40, 0, -1);
    @(negedge clk);
    vectors++;
    if (s_axis_tready !== 1'b0) begin miscompares++; $display("FAIL report_tready: got %0b required 0", s_axis_tready); end
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    vectors++;
    if (s_axis_tready !== 1'b1) begin miscompares++; $display("FAIL post_report_tready: got %0b required 1", s_axis_tready); end
    idle(2);
  endtask

  task automatic test_reset_mid;
    foreach (fr[i]) fr[i] = 50;
    send_frame(NB, 100, 0, 128);
    s_axis_tvalid = 1'b0;
    #3 reset_b = 1'b0;
    #1;
    vectors += 3;
    if (Index_out !== '0 || Peak_out !== '0) begin miscompares++; $display("FAIL async_rst_out: Index_out=%0d Peak_out=%0d required 0 0", Index_out, Peak_out); end
    if (Index_valid !== 1'b0 || Frame_error !== 1'b0) begin miscompares++; $display("FAIL async_rst_pulse: %0b %0b required 0 0", Index_valid, Frame_error); end
    if (s_axis_tready !== 1'b0) begin miscompares++; $display("FAIL async_rst_tready: got %0b required 0", s_axis_tready); end
    good_idx = '0; good_pk = '0;
    @(negedge clk); reset_b = 1'b1;
    @(posedge clk); #1;
    foreach (fr[i]) fr[i] = -7;
    fr[3] = 9;
    send_frame(NB, 100, 0, -1);
    idle(2);
  endtask

  task automatic test_back_to_back;
    pulse_cyc.delete();
    foreach (fr[i]) fr[i] = 1;
    fr[7] = 20000;
    send_frame(NB, 100, 0, -1);
    foreach (fr[i]) fr[i] = 1;
    fr[250] = 21000;
    send_frame(NB, 100, 0, -1);
    idle(3);
    vectors++;
    if (pulse_cyc.size() != 2) begin
      miscompares++; $display("FAIL b2b_count: %0d pulses required 2", pulse_cyc.size());
    end else if (pulse_cyc[1] - pulse_cyc[0] != NB + 1) begin
      miscompares++; $display("FAIL b2b_spacing: %0d cycles required %0d", pulse_cyc[1] - pulse_cyc[0], NB + 1);
    end
  endtask

  initial begin
    test_reset;
    test_single_peak;
    test_ties;
    test_bad_frames;
    test_random_duty;
    test_reset_mid;
    test_back_to_back;
    idle(5);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++; $display("FAIL pending: %0d results never reported, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
